// File: rtl/morse_playback.sv
// Morse playback engine: fetches 10-bit code words (5 x 2-bit symbols, MSB first)
// from RAM and plays them as timed on/off pulses on a single registered LED output.
module morse_playback #(
  parameter int UNIT_TICKS = 25000000,
  parameter int ADDR_W     = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [9:0]        ram_q,
  output logic              led,
  output logic [1:0]        symbol,
  output logic [ADDR_W-1:0] word_idx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(3 * UNIT_TICKS);
  localparam logic [CNT_W-1:0] ONE_UNIT    = CNT_W'(UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] THREE_UNITS = CNT_W'(3 * UNIT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_ON    = 3'd4,
    S_GAP   = 3'd5,
    S_LGAP  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // 01 = dot, 11 = dash; 00 and 10 terminate the letter
  function automatic logic is_mark(input logic [1:0] sym);
    return sym[0];
  endfunction

  function automatic logic [CNT_W-1:0] on_time(input logic [1:0] sym);
    return sym[1] ? THREE_UNITS : ONE_UNIT;
  endfunction

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [9:0]        shreg_r, shreg_next_s;
  logic [2:0]        sym_cnt_r, sym_cnt_next_s;
  logic [ADDR_W-1:0] word_idx_r, word_idx_next_s;
  logic [ADDR_W-1:0] wcount_r, wcount_next_s;
  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_rd_r;
  logic              led_r;
  logic [1:0]        symbol_r;
  logic              busy_r;
  logic              done_r;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath update; abort overrides every transition
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = (cnt_r != {CNT_W{1'b0}}) ? cnt_r - CNT_W'(1) : cnt_r;
    shreg_next_s    = shreg_r;
    sym_cnt_next_s  = sym_cnt_r;
    word_idx_next_s = word_idx_r;
    wcount_next_s   = wcount_r;
    if (abort) begin
      state_next_s    = S_IDLE;
      cnt_next_s      = {CNT_W{1'b0}};
      word_idx_next_s = {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            wcount_next_s   = word_count;
            word_idx_next_s = {ADDR_W{1'b0}};
            state_next_s    = (word_count != {ADDR_W{1'b0}}) ? S_FETCH : S_DONE;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_FETCH: state_next_s = S_WAIT;
        S_WAIT: begin
          shreg_next_s   = ram_q;
          sym_cnt_next_s = 3'd0;
          state_next_s   = S_LOAD;
        end
        S_LOAD: begin
          if (is_mark(shreg_r[9:8])) begin
            state_next_s = S_ON;
            cnt_next_s   = on_time(shreg_r[9:8]);
          end else begin
            state_next_s = S_LGAP;
            cnt_next_s   = THREE_UNITS;
          end
        end
        S_ON: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            shreg_next_s   = {shreg_r[7:0], 2'b00};
            sym_cnt_next_s = sym_cnt_r + 3'd1;
            // shreg_r[7:6] is the symbol that becomes the top after the shift
            if ((sym_cnt_r == 3'd4) || !is_mark(shreg_r[7:6])) begin
              state_next_s = S_LGAP;
              cnt_next_s   = THREE_UNITS;
            end else begin
              state_next_s = S_GAP;
              cnt_next_s   = ONE_UNIT;
            end
          end else begin
            state_next_s = S_ON;
          end
        end
        S_GAP: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_next_s = S_ON;
            cnt_next_s   = on_time(shreg_r[9:8]);
          end else begin
            state_next_s = S_GAP;
          end
        end
        S_LGAP: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            word_idx_next_s = word_idx_r + ADDR_W'(1);
            if ((word_idx_r + ADDR_W'(1)) == wcount_r) begin
              state_next_s = S_DONE;
            end else begin
              state_next_s = S_FETCH;
            end
          end else begin
            state_next_s = S_LGAP;
          end
        end
        S_DONE: begin
          state_next_s    = S_IDLE;
          word_idx_next_s = {ADDR_W{1'b0}};
        end
        default: begin
          state_next_s    = S_IDLE;
          word_idx_next_s = {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Datapath registers and outputs, registered from the next state so they align with it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r      <= {CNT_W{1'b0}};
      shreg_r    <= 10'd0;
      sym_cnt_r  <= 3'd0;
      word_idx_r <= {ADDR_W{1'b0}};
      wcount_r   <= {ADDR_W{1'b0}};
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_rd_r   <= 1'b0;
      led_r      <= 1'b0;
      symbol_r   <= 2'b00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      shreg_r    <= shreg_next_s;
      sym_cnt_r  <= sym_cnt_next_s;
      word_idx_r <= word_idx_next_s;
      wcount_r   <= wcount_next_s;
      ram_addr_r <= word_idx_next_s;
      ram_rd_r   <= (state_next_s == S_FETCH);
      led_r      <= (state_next_s == S_ON);
      symbol_r   <= (state_next_s == S_ON) ? shreg_next_s[9:8] : 2'b00;
      busy_r     <= (state_next_s != S_IDLE);
      done_r     <= (state_next_s == S_DONE);
    end
  end

  assign ram_addr = ram_addr_r;
  assign ram_rd   = ram_rd_r;
  assign led      = led_r;
  assign symbol   = symbol_r;
  assign word_idx = word_idx_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
